// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: host-programmed duty ramp sequencer for the picomem PWM.
// Writes the period once, then walks the duty toward target every N co pulses.
module pwm_ramp_ctrl #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] wrdata,
  input  logic          write,
  output logic [DW-1:0] rddata,
  output logic          pwm_addr,
  output logic [DW-1:0] pwm_wrdata,
  output logic          pwm_write,
  input  logic          pwm_co
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_period;
  logic [DW-1:0] r_target;
  logic [DW-1:0] r_step;
  logic [CW-1:0] r_dwell;
  logic [DW-1:0] r_wperiod;
  logic [DW-1:0] r_wtarget;
  logic [DW-1:0] r_wstep;
  logic [CW-1:0] r_wdwell;
  logic [DW-1:0] r_cur;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic          w_ctrl_wr;
  logic          w_start;
  logic          w_stop;
  logic          w_busy;
  logic [CW-1:0] w_dmax;
  logic [CW-1:0] w_cnt_inc;
  logic [DW-1:0] w_s;
  logic [DW-1:0] w_cur_step;
  logic          w_latch;
  logic          w_cur_en;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_nxt;

  assign w_ctrl_wr = write && (addr == 3'd3);
  assign w_start   = w_ctrl_wr && wrdata[DW-1] && !wrdata[DW-2];
  assign w_stop    = w_ctrl_wr && wrdata[DW-2];
  assign w_busy    = (r_state != S_IDLE);
  assign w_dmax    = (r_wdwell == '0) ? CW'(1) : r_wdwell;
  assign w_cnt_inc = r_cnt + 1'b1;
  // STEP of zero means a single jump straight to the target
  assign w_s       = (r_wstep == '0) ? '1 : r_wstep;

  always_comb begin
    w_cur_step = r_cur;
    unique case (1'b1)
      (r_cur < r_wtarget):
        w_cur_step = (r_wtarget - r_cur <= w_s) ?
                     r_wtarget : r_cur + w_s;
      (r_cur > r_wtarget):
        w_cur_step = (r_cur - r_wtarget <= w_s) ?
                     r_wtarget : r_cur - w_s;
      default:
        w_cur_step = r_cur;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cur_en    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    pwm_write   = 1'b0;
    pwm_addr    = 1'b1;
    pwm_wrdata  = r_cur;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
        end
      end
      S_LOAD, S_WRITE: begin
        pwm_write = 1'b1;
        if (r_state == S_LOAD) begin
          pwm_addr   = 1'b0;
          pwm_wrdata = r_wperiod;
        end
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cur == r_wtarget) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (pwm_co) begin
          if (w_cnt_inc == w_dmax) begin
            w_cnt_nxt   = '0;
            w_cur_en    = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_cur_en) r_cur <= w_cur_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_target  <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_wperiod <= '0;
      r_wtarget <= '0;
      r_wstep   <= '0;
      r_wdwell  <= '0;
    end else begin
      if (write) begin
        unique case (addr)
          3'd0:    r_period <= wrdata;
          3'd1:    r_target <= wrdata;
          3'd2:    r_step   <= wrdata;
          3'd3:    r_dwell  <= wrdata[CW-1:0];
          default: ;
        endcase
      end
      if (w_latch) begin
        r_wperiod <= r_period;
        r_wtarget <= r_target;
        r_wstep   <= r_step;
        r_wdwell  <= wrdata[CW-1:0];
      end
    end
  end

  always_comb begin
    rddata = '0;
    unique case (addr)
      3'd0: rddata = r_period;
      3'd1: rddata = r_target;
      3'd2: rddata = r_step;
      3'd3: begin
        rddata[DW-1]   = w_busy;
        rddata[DW-2]   = r_done;
        rddata[CW-1:0] = r_dwell;
      end
      3'd4:    rddata = r_cur;
      default: rddata = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed + randomized bench for pwm_ramp_ctrl.
// Expected PWM writes come from a transaction-level ramp model.
module tb_pwm_ramp_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [DW-1:0] START = 32'h8000_0000;
  localparam logic [DW-1:0] STOP  = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    addr;
  logic [DW-1:0] wrdata;
  logic          write;
  logic [DW-1:0] rddata;
  logic          pwm_addr;
  logic [DW-1:0] pwm_wrdata;
  logic          pwm_write;
  logic          pwm_co;

  pwm_ramp_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .wrdata     (wrdata),
    .write      (write),
    .rddata     (rddata),
    .pwm_addr   (pwm_addr),
    .pwm_wrdata (pwm_wrdata),
    .pwm_write  (pwm_write),
    .pwm_co     (pwm_co)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] h_period, h_target, h_step;
  logic [CW-1:0] h_dwell;
  logic [DW-1:0] m_period, m_target, m_step;
  logic [DW-1:0] m_cur;
  logic          m_done, m_busy;
  logic          m_wr_now, m_wr_addr;
  logic [DW-1:0] m_wr_data;
  int            m_cnt, m_dmax;
  logic [DW-1:0] q[$];

  task automatic mreset();
    h_period = '0; h_target = '0; h_step = '0; h_dwell = '0;
    m_cur = '0; m_done = 0; m_busy = 0;
    m_wr_now = 0; m_wr_addr = 1; m_wr_data = '0;
    m_cnt = 0; m_dmax = 1;
    q.delete();
  endtask

  // full list of duty values the ramp visits, by plain arithmetic
  function automatic void plan(input logic [DW-1:0] c0,
                               input logic [DW-1:0] t,
                               input logic [DW-1:0] st);
    longint c, tt, s;
    c = c0; tt = t;
    s = (st == 0) ? 64'h1_0000_0000 : longint'(st);
    q.delete();
    while (c != tt) begin
      if (c < tt) c = (tt - c <= s) ? tt : c + s;
      else        c = (c - tt <= s) ? tt : c - s;
      q.push_back(DW'(c));
    end
  endfunction

  function automatic logic rco();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // at a negedge: check outputs, drive inputs, advance model, next negedge
  task automatic tick(input bit do_wr, input logic [2:0] wa,
                      input logic [DW-1:0] wd, input bit co);
    bit st, sp;
    chk("pwm_write", pwm_write, m_wr_now);
    chk("pwm_addr", pwm_addr, m_wr_now ? m_wr_addr : 1'b1);
    chk("pwm_wrdata", pwm_wrdata, m_wr_now ? m_wr_data : m_cur);
    addr = 3'd3; #1;
    chk("ctrl_rd", rddata, {m_busy, m_done, 14'd0, h_dwell});
    addr = 3'd4; #1;
    chk("cur_rd", rddata, m_cur);
    addr   = do_wr ? wa : 3'd3;
    wrdata = wd;
    write  = do_wr;
    pwm_co = co;
    sp = do_wr && wa == 3'd3 && wd[30];
    st = do_wr && wa == 3'd3 && wd[31] && !wd[30];
    if (do_wr) begin
      case (wa)
        3'd0: h_period = wd;
        3'd1: h_target = wd;
        3'd2: h_step   = wd;
        3'd3: h_dwell  = wd[CW-1:0];
        default: ;
      endcase
    end
    if (!m_busy) begin
      if (st) begin
        m_period = h_period; m_target = h_target; m_step = h_step;
        m_dmax = (h_dwell == 0) ? 1 : int'(h_dwell);
        plan(m_cur, m_target, m_step);
        m_done = 0; m_busy = 1; m_cnt = 0;
        m_wr_now = 1; m_wr_addr = 0; m_wr_data = m_period;
      end
    end else if (sp) begin
      m_busy = 0; m_wr_now = 0;
    end else if (m_wr_now) begin
      m_wr_now = 0;
      if (q.size() == 0) begin
        m_busy = 0; m_done = 1;
      end
    end else if (co) begin
      m_cnt++;
      if (m_cnt == m_dmax) begin
        m_cnt = 0;
        m_cur = q.pop_front();
        m_wr_now = 1; m_wr_addr = 1; m_wr_data = m_cur;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hw(input logic [2:0] a, input logic [DW-1:0] d);
    tick(1, a, d, rco());
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      tick(0, 3'd0, '0, rco());
      n++;
    end
    addr = 3'd3; #1;
    chk("idle_after_run", {31'd0, rddata[31]}, '0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [DW-1:0] exp,
                    input string tag);
    addr = a; #1;
    chk(tag, rddata, exp);
  endtask

  task automatic rand_run();
    logic [2:0] a;
    logic [DW-1:0] d;
    hw(3'd0, $urandom);
    hw(3'd1, $urandom_range(0, 400));
    if (m_cur > 1000 || $urandom_range(0, 3) == 0) hw(3'd2, '0);
    else hw(3'd2, $urandom_range(15, 120));
    hw(3'd3, START | $urandom_range(0, 3));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        a = 3'($urandom_range(0, 7));
        case (a)
          3'd3: d = ($urandom & 32'hC000_0000) | $urandom_range(0, 3);
          3'd2: d = $urandom_range(16, 200);
          default: d = $urandom_range(0, 400);
        endcase
        tick(1, a, d, rco());
      end else begin
        tick(0, 3'd0, '0, rco());
      end
    end
    drain(20000);
  endtask

  initial begin
    mreset();
    rst_n = 0; addr = 3'd0; wrdata = '0; write = 0; pwm_co = 0;
    #12;
    chk("rst_pwm_write", pwm_write, 0);
    chk("rst_pwm_addr", pwm_addr, 1);
    chk("rst_pwm_wrdata", pwm_wrdata, 0);
    for (int i = 0; i < 8; i++) rd(3'(i), '0, "rst_reg");
    @(negedge clk);
    rst_n = 1;

    hw(3'd0, 100); hw(3'd1, 50); hw(3'd2, 20); hw(3'd3, START | 2);
    drain(2000);
    rd(3'd4, 50, "t1_cur");
    rd(3'd3, START >> 1 | 2, "t1_ctrl");

    hw(3'd1, 0); hw(3'd2, 30); hw(3'd3, START | 1);
    drain(2000);
    rd(3'd4, 0, "t2_cur");

    hw(3'd2, 0); hw(3'd1, 77); hw(3'd3, START | 3);
    drain(2000);
    rd(3'd4, 77, "t3_cur");

    hw(3'd1, 60); hw(3'd2, 5); hw(3'd3, START | 1);
    for (int i = 0; i < 4; i++) tick(0, 3'd0, '0, rco());
    hw(3'd1, 999);
    hw(3'd3, START | 2);
    drain(2000);
    rd(3'd4, 60, "t4_cur");
    rd(3'd1, 999, "t4_target_rd");

    hw(3'd1, 0); hw(3'd2, 7); hw(3'd3, START | 2);
    for (int i = 0; i < 12; i++) tick(0, 3'd0, '0, 1'b1);
    hw(3'd3, STOP | 2);
    for (int i = 0; i < 8; i++) tick(0, 3'd0, '0, 1'b1);
    rd(3'd3, 32'd2, "t5_stopped");

    hw(3'd3, START | STOP | 1);
    tick(0, 3'd0, '0, 1'b1);
    hw(3'd1, m_cur); hw(3'd3, START | 1);
    drain(200);
    rd(3'd3, STOP | 1, "t6_same_target");

    hw(3'd0, $urandom); hw(3'd1, 32'hFFFF_FFF0);
    hw(3'd2, 32'h9000_0000); hw(3'd3, START | 1);
    drain(2000);
    hw(3'd1, 3); hw(3'd2, 0); hw(3'd3, START);
    drain(2000);
    rd(3'd4, 3, "big_back");

    for (int r = 0; r < 30; r++) rand_run();

    hw(3'd1, 300); hw(3'd2, 40); hw(3'd3, START | 3);
    for (int i = 0; i < 12; i++) tick(0, 3'd0, '0, 1'b1);
    tick(0, 3'd0, '0, 1'b0);
    #2 rst_n = 0;
    #1;
    chk("arst_pwm_write", pwm_write, 0);
    chk("arst_pwm_addr", pwm_addr, 1);
    chk("arst_pwm_wrdata", pwm_wrdata, 0);
    pwm_co = 1;
    @(posedge clk); #1;
    chk("arst_hold_write", pwm_write, 0);
    for (int i = 0; i < 5; i++) rd(3'(i), '0, "arst_reg");
    @(negedge clk);
    rst_n = 1; pwm_co = 0;
    mreset();
    tick(0, 3'd0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
